// File: rtl/clk_period_meter.sv
// Measures the high and low phase lengths of an asynchronous square wave in basys_clock cycles.
// Results update only as a complete high+low pair, marked by a one-cycle meas_valid pulse.
module clk_period_meter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 100_000_000
) (
  input  logic             basys_clock,
  input  logic             reset,
  input  logic             sig_in,
  output logic [WIDTH-1:0] high_cycles,
  output logic [WIDTH-1:0] low_cycles,
  output logic [WIDTH:0]   period_cycles,
  output logic [WIDTH-1:0] m_est,
  output logic             meas_valid,
  output logic             symmetric,
  output logic             stalled
);

  localparam logic [WIDTH-1:0] TO_LIM = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] high;
    logic [WIDTH-1:0] low;
    logic [WIDTH:0]   period;
    logic [WIDTH-1:0] m_est;
    logic             sym;
  } meas_t;

  // Input conditioning: two-flop synchronizer, previous-value flop, registered edge pulses.
  logic [1:0] sync_q;
  logic       prev_q;
  logic       rise_q, fall_q;
  logic       rise, fall;

  assign rise = sync_q[1] & ~prev_q;
  assign fall = ~sync_q[1] & prev_q;

  always_ff @(posedge basys_clock) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sig_in};
      prev_q <= sync_q[1];
      rise_q <= rise;
      fall_q <= fall;
    end
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  meas_t            meas_q, meas_d;
  logic             valid_q, valid_d;
  logic             stalled_q, stalled_d;
  logic             in_meas, at_limit;
  logic             accept, close;

  assign in_meas  = (state_q != IDLE);
  assign at_limit = (cnt_q == TO_LIM);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    meas_d    = meas_q;
    valid_d   = 1'b0;
    stalled_d = stalled_q;
    accept    = 1'b0;
    close     = 1'b0;

    // An edge arriving on the same cycle the limit is hit is still accepted.
    case (state_q)
      IDLE: begin
        if (rise_q) begin
          state_d = MEAS_HIGH;
          accept  = 1'b1;
        end
      end
      MEAS_HIGH: begin
        if (fall_q) begin
          state_d = MEAS_LOW;
          accept  = 1'b1;
          hold_d  = cnt_q;
        end else if (at_limit) begin
          state_d = IDLE;
        end
      end
      MEAS_LOW: begin
        if (rise_q) begin
          state_d = MEAS_HIGH;
          accept  = 1'b1;
          close   = 1'b1;
        end else if (at_limit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept)
      cnt_d = ONE;
    else if (in_meas && !at_limit)
      cnt_d = cnt_q + ONE;

    if (close) begin
      meas_d.high   = hold_q;
      meas_d.low    = cnt_q;
      meas_d.period = {1'b0, hold_q} + {1'b0, cnt_q};
      meas_d.m_est  = hold_q - ONE;
      meas_d.sym    = (hold_q == cnt_q);
      valid_d       = 1'b1;
      stalled_d     = 1'b0;
    end

    // A phase that saturated the counter keeps stalled set even when it closes a period.
    if (in_meas && at_limit)
      stalled_d = 1'b1;
  end

  always_ff @(posedge basys_clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      meas_q    <= '0;
      valid_q   <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      meas_q    <= meas_d;
      valid_q   <= valid_d;
      stalled_q <= stalled_d;
    end
  end

  assign high_cycles   = meas_q.high;
  assign low_cycles    = meas_q.low;
  assign period_cycles = meas_q.period;
  assign m_est         = meas_q.m_est;
  assign symmetric     = meas_q.sym;
  assign meas_valid    = valid_q;
  assign stalled       = stalled_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: three instances cover the default width,
// a short timeout and a 4-bit width with counter saturation.
module tb_clk_period_meter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig_a = 1'b0, sig_b = 1'b0, sig_c = 1'b0;

  logic [31:0] hc_a, lc_a, me_a;
  logic [32:0] pc_a;
  logic        mv_a, sym_a, stl_a;
  logic [31:0] hc_b, lc_b, me_b;
  logic [32:0] pc_b;
  logic        mv_b, sym_b, stl_b;
  logic [3:0]  hc_c, lc_c, me_c;
  logic [4:0]  pc_c;
  logic        mv_c, sym_c, stl_c;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  clk_period_meter #(.WIDTH(32)) dut_a (
    .basys_clock(clk), .reset(rst), .sig_in(sig_a),
    .high_cycles(hc_a), .low_cycles(lc_a), .period_cycles(pc_a), .m_est(me_a),
    .meas_valid(mv_a), .symmetric(sym_a), .stalled(stl_a)
  );

  clk_period_meter #(.WIDTH(32), .TIMEOUT(20)) dut_b (
    .basys_clock(clk), .reset(rst), .sig_in(sig_b),
    .high_cycles(hc_b), .low_cycles(lc_b), .period_cycles(pc_b), .m_est(me_b),
    .meas_valid(mv_b), .symmetric(sym_b), .stalled(stl_b)
  );

  clk_period_meter #(.WIDTH(4), .TIMEOUT(15)) dut_c (
    .basys_clock(clk), .reset(rst), .sig_in(sig_c),
    .high_cycles(hc_c), .low_cycles(lc_c), .period_cycles(pc_c), .m_est(me_c),
    .meas_valid(mv_c), .symmetric(sym_c), .stalled(stl_c)
  );

  // Leaves the bench on a negedge with reset released and all inputs low.
  task automatic apply_reset();
    @(negedge clk);
    sig_a = 1'b0; sig_b = 1'b0; sig_c = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    sig_a = 1'b1; sig_b = 1'b1; sig_c = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({hc_a, lc_a, pc_a, me_a, mv_a, sym_a, stl_a} !== '0)
      $display("FAIL reset_a hi=%0d lo=%0d per=%0d m=%0d mv=%0b sym=%0b stl=%0b exp all 0",
               hc_a, lc_a, pc_a, me_a, mv_a, sym_a, stl_a);
    else n_pass++;
    n_chk++;
    if ({hc_b, lc_b, pc_b, me_b, mv_b, sym_b, stl_b} !== '0)
      $display("FAIL reset_b hi=%0d lo=%0d per=%0d m=%0d mv=%0b sym=%0b stl=%0b exp all 0",
               hc_b, lc_b, pc_b, me_b, mv_b, sym_b, stl_b);
    else n_pass++;
    n_chk++;
    if ({hc_c, lc_c, pc_c, me_c, mv_c, sym_c, stl_c} !== '0)
      $display("FAIL reset_c hi=%0d lo=%0d per=%0d m=%0d mv=%0b sym=%0b stl=%0b exp all 0",
               hc_c, lc_c, pc_c, me_c, mv_c, sym_c, stl_c);
    else n_pass++;
  endtask

  // m=4 divider: 5 high / 5 low; closing rise at step 10 -> meas_valid sampled after posedge 13.
  task automatic test_m4();
    logic exp_mv;
    apply_reset();
    for (int k = 0; k < 45; k++) begin
      sig_a = ((k / 5) % 2) == 0;
      @(posedge clk); #1;
      exp_mv = (k >= 13) && (((k - 13) % 10) == 0);
      n_chk++;
      if (mv_a !== exp_mv) $display("FAIL m4_valid step=%0d got=%0b exp=%0b", k, mv_a, exp_mv);
      else n_pass++;
      if (k == 12) begin
        n_chk++;
        if ({hc_a, lc_a, pc_a, me_a, sym_a} !== '0)
          $display("FAIL m4_no_partial step=%0d hi=%0d lo=%0d exp 0/0", k, hc_a, lc_a);
        else n_pass++;
      end
      if (k == 13 || k == 43) begin
        n_chk++;
        if (hc_a !== 32'd5 || lc_a !== 32'd5 || pc_a !== 33'd10 || me_a !== 32'd4 ||
            sym_a !== 1'b1 || stl_a !== 1'b0)
          $display("FAIL m4_values step=%0d hi=%0d lo=%0d per=%0d m=%0d sym=%0b stl=%0b exp 5/5/10/4/1/0",
                   k, hc_a, lc_a, pc_a, me_a, sym_a, stl_a);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  // m=0 divider: toggles every cycle.
  task automatic test_m0();
    logic exp_mv;
    apply_reset();
    for (int k = 0; k < 20; k++) begin
      sig_a = (k % 2) == 0;
      @(posedge clk); #1;
      exp_mv = (k >= 5) && (((k - 5) % 2) == 0);
      n_chk++;
      if (mv_a !== exp_mv) $display("FAIL m0_valid step=%0d got=%0b exp=%0b", k, mv_a, exp_mv);
      else n_pass++;
      if (k == 5 || k == 19) begin
        n_chk++;
        if (hc_a !== 32'd1 || lc_a !== 32'd1 || pc_a !== 33'd2 || me_a !== 32'd0 || sym_a !== 1'b1)
          $display("FAIL m0_values step=%0d hi=%0d lo=%0d per=%0d m=%0d sym=%0b exp 1/1/2/0/1",
                   k, hc_a, lc_a, pc_a, me_a, sym_a);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  // 3 high / 7 low.
  task automatic test_asym();
    logic exp_mv;
    apply_reset();
    for (int k = 0; k < 25; k++) begin
      sig_a = (k % 10) < 3;
      @(posedge clk); #1;
      exp_mv = (k == 13) || (k == 23);
      n_chk++;
      if (mv_a !== exp_mv) $display("FAIL asym_valid step=%0d got=%0b exp=%0b", k, mv_a, exp_mv);
      else n_pass++;
      if (k == 13 || k == 23) begin
        n_chk++;
        if (hc_a !== 32'd3 || lc_a !== 32'd7 || pc_a !== 33'd10 || me_a !== 32'd2 || sym_a !== 1'b0)
          $display("FAIL asym_values step=%0d hi=%0d lo=%0d per=%0d m=%0d sym=%0b exp 3/7/10/2/0",
                   k, hc_a, lc_a, pc_a, me_a, sym_a);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  // TIMEOUT=20: high for 30 steps, low 10, then a 5/5 wave. First counted cycle is step 3.
  task automatic test_timeout();
    logic exp_mv;
    apply_reset();
    for (int k = 0; k < 56; k++) begin
      if (k < 30)      sig_b = 1'b1;
      else if (k < 40) sig_b = 1'b0;
      else             sig_b = (((k - 40) / 5) % 2) == 0;
      @(posedge clk); #1;
      exp_mv = (k == 53);
      n_chk++;
      if (mv_b !== exp_mv) $display("FAIL to_valid step=%0d got=%0b exp=%0b", k, mv_b, exp_mv);
      else n_pass++;
      if (k == 22 || k == 23 || k == 44 || k == 53) begin
        n_chk++;
        if (stl_b !== (k == 23 || k == 44))
          $display("FAIL to_stalled step=%0d got=%0b exp=%0b", k, stl_b, (k == 23 || k == 44));
        else n_pass++;
      end
      if (k == 52) begin
        n_chk++;
        if ({hc_b, lc_b, pc_b, me_b, sym_b} !== '0)
          $display("FAIL to_hold step=%0d hi=%0d lo=%0d per=%0d exp 0/0/0", k, hc_b, lc_b, pc_b);
        else n_pass++;
      end
      if (k == 53) begin
        n_chk++;
        if (hc_b !== 32'd5 || lc_b !== 32'd5 || pc_b !== 33'd10 || me_b !== 32'd4 || sym_b !== 1'b1)
          $display("FAIL to_values step=%0d hi=%0d lo=%0d per=%0d m=%0d sym=%0b exp 5/5/10/4/1",
                   k, hc_b, lc_b, pc_b, me_b, sym_b);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  // m=4 wave with reset pulsed at step 19 (FSM in MEAS_LOW); sig_in is high when reset drops.
  task automatic test_reset_mid();
    logic exp_mv;
    apply_reset();
    for (int k = 0; k < 45; k++) begin
      rst = (k == 19);
      sig_a = ((k / 5) % 2) == 0;
      @(posedge clk); #1;
      exp_mv = (k == 13) || (k == 33) || (k == 43);
      n_chk++;
      if (mv_a !== exp_mv) $display("FAIL rmid_valid step=%0d got=%0b exp=%0b", k, mv_a, exp_mv);
      else n_pass++;
      if (k == 19) begin
        n_chk++;
        if ({hc_a, lc_a, pc_a, me_a, mv_a, sym_a, stl_a} !== '0)
          $display("FAIL rmid_clear step=%0d hi=%0d lo=%0d per=%0d m=%0d exp all 0",
                   k, hc_a, lc_a, pc_a, me_a);
        else n_pass++;
      end
      if (k == 33) begin
        n_chk++;
        if (hc_a !== 32'd5 || lc_a !== 32'd5 || pc_a !== 33'd10 || me_a !== 32'd4 || sym_a !== 1'b1)
          $display("FAIL rmid_values step=%0d hi=%0d lo=%0d per=%0d m=%0d sym=%0b exp 5/5/10/4/1",
                   k, hc_a, lc_a, pc_a, me_a, sym_a);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  // WIDTH=4, TIMEOUT=15: 15/15 wave saturates the counter in each phase.
  task automatic test_narrow();
    logic exp_mv;
    apply_reset();
    for (int k = 0; k < 36; k++) begin
      sig_c = ((k / 15) % 2) == 0;
      @(posedge clk); #1;
      exp_mv = (k == 33);
      n_chk++;
      if (mv_c !== exp_mv) $display("FAIL w4_valid step=%0d got=%0b exp=%0b", k, mv_c, exp_mv);
      else n_pass++;
      if (k == 17 || k == 18) begin
        n_chk++;
        if (stl_c !== (k == 18)) $display("FAIL w4_stalled step=%0d got=%0b exp=%0b", k, stl_c, (k == 18));
        else n_pass++;
      end
      if (k == 33) begin
        n_chk++;
        if (hc_c !== 4'd15 || lc_c !== 4'd15 || pc_c !== 5'd30 || me_c !== 4'd14 ||
            sym_c !== 1'b1 || stl_c !== 1'b1)
          $display("FAIL w4_values step=%0d hi=%0d lo=%0d per=%0d m=%0d sym=%0b stl=%0b exp 15/15/30/14/1/1",
                   k, hc_c, lc_c, pc_c, me_c, sym_c, stl_c);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_m4();
    test_m0();
    test_asym();
    test_timeout();
    test_reset_mid();
    test_narrow();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
